// File: rtl/led_counter_gen.sv
// Parametrised LED step counter: prescaled up/down counter with wrap (or saturate) and parallel load.
// Latency: led/tc/step registered, all updated on the same tick edge; load visible one cycle after strobe.
// Backpressure: none; en freezes the prescaler phase and the count, nothing is dropped or queued.
//
// Ports:
//   clk       rising-edge system clock
//   reset     synchronous active-low reset (clears count, prescaler and pulses)
//   en        count enable; prescaler advances only while high
//   up        direction, 1 = increment, 0 = decrement (sampled at tick)
//   load      synchronous parallel load strobe, wins over a tick on the same edge
//   load_val  value to load, clamped to MAX_VAL
//   led       current count, 0..MAX_VAL
//   tc        one-cycle terminal-count pulse, aligned with the led change
//   step      one-cycle prescaler tick, aligned with the led change
//
// Build option: define LEDCNT_SATURATE_EN to make the counter stick at its
// limits (tc still pulses on every tick that hits the limit) instead of wrapping.

module led_counter_gen #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             tc,
    output logic             step
);

    // Prescaler needs at least one bit even when PRESCALE is 1; in that case
    // it sits at 0 permanently and every enabled edge is a tick.
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] LED_MAX  = WIDTH'(MAX_VAL);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic             at_limit;
    logic [WIDTH-1:0] step_led;
    logic [WIDTH-1:0] load_clamped;

    assign tick = en && (pre_cnt == PRE_LAST);

    // The limit depends on direction: MAX_VAL going up, 0 going down. Comparing
    // against MAX_VAL rather than all-ones keeps non-binary moduli exact.
    assign at_limit = up ? (led == LED_MAX) : (led == '0);

    assign load_clamped = (load_val > LED_MAX) ? LED_MAX : load_val;

    // Count value to take on a tick.
    always_comb begin
        step_led = led;
        if (at_limit) begin
`ifdef LEDCNT_SATURATE_EN
            step_led = led;
`else
            step_led = up ? '0 : LED_MAX;
`endif
        end else if (up) begin
            step_led = led + WIDTH'(1);
        end else begin
            step_led = led - WIDTH'(1);
        end
    end

    // Priority: reset, load, tick, hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_cnt <= '0;
            led     <= '0;
            tc      <= 1'b0;
            step    <= 1'b0;
        end else if (load) begin
            // Load restarts the prescale phase so the next step is a full
            // PRESCALE edges away, even if this edge would have ticked.
            pre_cnt <= '0;
            led     <= load_clamped;
            tc      <= 1'b0;
            step    <= 1'b0;
        end else if (tick) begin
            pre_cnt <= '0;
            led     <= step_led;
            tc      <= at_limit;
            step    <= 1'b1;
        end else begin
            tc   <= 1'b0;
            step <= 1'b0;
            if (en) begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_counter_gen.sv
// Testbench for led_counter_gen: three configurations driven by shared stimulus,
// checked against a modular-arithmetic reference model through a scoreboard queue.
// Directed phases first (reset/wrap, prescale + en gap, down count, load, mid-phase reset, limits), then random.

module tb_led_counter_gen;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] led0, led1, led2;
    logic       tc0, tc1, tc2;
    logic       step0, step1, step2;

    always #5 clk = ~clk;

    // A: full binary range, no prescale.
    led_counter_gen #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1)) u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .led(led0), .tc(tc0), .step(step0)
    );
    // B: decade counter, prescale 5.
    led_counter_gen #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(5)) u_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .led(led1), .tc(tc1), .step(step1)
    );
    // C: modulus 7, power-of-two prescale.
    led_counter_gen #(.WIDTH(4), .MAX_VAL(6), .PRESCALE(4)) u_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .led(led2), .tc(tc2), .step(step2)
    );

    int maxv [NI] = '{15, 9, 6};
    int pres [NI] = '{1, 5, 4};
    int m_led[NI] = '{0, 0, 0};
    int m_pre[NI] = '{0, 0, 0};
    bit sat;

    typedef struct packed {
        logic [3:0] led;
        logic       tc;
        logic       step;
    } exp_t;
    typedef exp_t [NI-1:0] exp3_t;

    exp3_t sbq[$];
    int    checks = 0;
    int    errors = 0;

    initial begin
`ifdef LEDCNT_SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
    end

    // Drive one clock's inputs and push the model's expected post-edge outputs.
    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv);
        exp3_t x;
        int    modn;
        logic  t;
        logic  s;
        @(negedge clk);
        reset = r; en = e; up = u; load = l; load_val = lv;
        for (int i = 0; i < NI; i++) begin
            modn = maxv[i] + 1;
            t = 1'b0;
            s = 1'b0;
            if (!r) begin
                m_led[i] = 0;
                m_pre[i] = 0;
            end else if (l) begin
                m_led[i] = (int'(lv) > maxv[i]) ? maxv[i] : int'(lv);
                m_pre[i] = 0;
            end else if (e) begin
                m_pre[i] = (m_pre[i] + 1) % pres[i];
                if (m_pre[i] == 0) begin
                    s = 1'b1;
                    if (u) begin
                        t = (m_led[i] == maxv[i]);
                        if (!(sat && t)) m_led[i] = (m_led[i] + 1) % modn;
                    end else begin
                        t = (m_led[i] == 0);
                        if (!(sat && t)) m_led[i] = (m_led[i] + modn - 1) % modn;
                    end
                end
            end
            x[i].led  = 4'(m_led[i]);
            x[i].tc   = t;
            x[i].step = s;
        end
        sbq.push_back(x);
    endtask

    task automatic check_one(input int i, input logic [3:0] l, input logic t,
                             input logic s, input exp_t e);
        checks++;
        if (l !== e.led || t !== e.tc || s !== e.step) begin
            errors++;
            $display("FAIL out_inst%0d t=%0t got led=%0d tc=%b step=%b expected led=%0d tc=%b step=%b",
                     i, $time, l, t, s, e.led, e.tc, e.step);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare after each edge.
    initial begin
        exp3_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                check_one(0, led0, tc0, step0, x[0]);
                check_one(1, led1, tc1, step1, x[1]);
                check_one(2, led2, tc2, step2, x[2]);
            end
        end
    end

    initial begin
        // Reset held two cycles, then count up through a full wrap of A.
        repeat (2) cyc(0, 0, 1, 0, 4'd0);
        repeat (20) cyc(1, 1, 1, 0, 4'd0);

        // Prescale with an en gap of 7 cycles mid-phase.
        repeat (3) cyc(1, 1, 1, 0, 4'd0);
        repeat (7) cyc(1, 0, 1, 0, 4'd0);
        repeat (12) cyc(1, 1, 1, 0, 4'd0);

        // Down count from reset across the non-binary modulus.
        cyc(0, 0, 0, 0, 4'd0);
        repeat (60) cyc(1, 1, 0, 0, 4'd0);

        // Load beyond MAX_VAL clamps.
        cyc(1, 1, 1, 1, 4'd12);
        repeat (3) cyc(1, 1, 1, 0, 4'd0);

        // Load on B's tick edge: load wins, phase restarts.
        cyc(0, 0, 1, 0, 4'd0);
        repeat (4) cyc(1, 1, 1, 0, 4'd0);
        cyc(1, 1, 1, 1, 4'd3);
        repeat (12) cyc(1, 1, 1, 0, 4'd0);

        // Mid-phase single-cycle reset.
        cyc(1, 1, 1, 1, 4'd6);
        repeat (2) cyc(1, 1, 1, 0, 4'd0);
        cyc(0, 1, 1, 0, 4'd0);
        repeat (10) cyc(1, 1, 1, 0, 4'd0);

        // Approach and sit at the upper limit, then turn around.
        cyc(1, 1, 1, 1, 4'd14);
        repeat (25) cyc(1, 1, 1, 0, 4'd0);
        repeat (12) cyc(1, 1, 0, 0, 4'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0),
                4'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sbq.size());
        end
        if (checks == 0) begin
            errors++;
            $display("FAIL no_checks got 0 expected nonzero");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
